// File: rtl/dffrsnq_ctrl_seq.sv
// dffrsnq_ctrl_seq: sequences the async RN/SETN controls and capture gate of a dffrsnq bank
module dffrsnq_ctrl_seq #(
  parameter int CW        = 4,
  parameter int PULSE_CYC = 2,
  parameter int SEP_CYC   = 1,
  parameter int REC_CYC   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [1:0] OP,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR,
  output logic       RN,
  output logic       SETN,
  output logic       CAP_EN
);
  typedef enum logic [2:0] {INIT, IDLE, QUIESCE, ASSERT, SEP, RECOVER, DONE} state_t;
  localparam logic [CW-1:0] PULSE_M1 = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SEP_M1   = CW'(SEP_CYC - 1);
  localparam logic [CW-1:0] REC_M1   = CW'(REC_CYC - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op;
  logic          from_req;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT;
      cnt      <= '0;
      op       <= '0;
      from_req <= 1'b0;
      RN       <= 1'b0;
      SETN     <= 1'b1;
      CAP_EN   <= 1'b0;
      BUSY     <= 1'b1;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        INIT:
          if (cnt == PULSE_M1) begin
            RN    <= 1'b1;
            state <= RECOVER;
            cnt   <= REC_M1;
          end else cnt <= cnt + 1'b1;
        // DONE accepts a held REQ so back-to-back sequences get exactly one open cycle
        IDLE, DONE: begin
          state <= IDLE;
          if (REQ && OP != 2'b00) begin
            op       <= OP;
            from_req <= 1'b1;
            state    <= QUIESCE;
            CAP_EN   <= 1'b0;
            BUSY     <= 1'b1;
          end else ERR <= REQ;
        end
        QUIESCE: begin
          RN    <= ~op[0];
          SETN  <= ~op[1];
          state <= ASSERT;
          cnt   <= PULSE_M1;
        end
        ASSERT:
          if (cnt == '0) begin
            RN <= 1'b1;
            if (op == 2'b11) begin
              state <= SEP;
              cnt   <= SEP_M1;
            end else begin
              SETN  <= 1'b1;
              state <= RECOVER;
              cnt   <= REC_M1;
            end
          end else cnt <= cnt - 1'b1;
        SEP:
          if (cnt == '0) begin
            SETN  <= 1'b1;
            state <= RECOVER;
            cnt   <= REC_M1;
          end else cnt <= cnt - 1'b1;
        RECOVER:
          if (cnt == '0) begin
            CAP_EN <= 1'b1;
            BUSY   <= 1'b0;
            ACK    <= from_req;
            state  <= from_req ? DONE : IDLE;
          end else cnt <= cnt - 1'b1;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_dffrsnq_ctrl_seq.sv
// tb_dffrsnq_ctrl_seq: directed bench with a timeline model of the control sequencer
module tb_dffrsnq_ctrl_seq;
  localparam int P = 2, S = 1, R = 2;
  logic CLK = 1'b0, RST = 1'b1, REQ = 1'b0;
  logic [1:0] OP = 2'b00;
  logic BUSY, ACK, ERR, RN, SETN, CAP_EN;
  int checks = 0, errors = 0;
  dffrsnq_ctrl_seq #(.CW(4), .PULSE_CYC(P), .SEP_CYC(S), .REC_CYC(R)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .BUSY(BUSY), .ACK(ACK),
    .ERR(ERR), .RN(RN), .SETN(SETN), .CAP_EN(CAP_EN)
  );
  always #5 CLK = ~CLK;
  task automatic chk(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask
  // Model: mode 0 = reset/init release, 1 = open, 2 = requested sequence; k = edges into the phase
  int mode = 0, k = 0;
  logic [1:0] mop = 2'b00;
  logic started = 1'b0;
  logic e_rn, e_setn, e_cap, e_busy, e_ack, e_err;
  initial forever begin
    @(posedge CLK);
    e_ack = 1'b0;
    e_err = 1'b0;
    if (RST) begin
      mode = 0;
      k = 0;
    end else if (mode == 1) begin
      if (REQ && OP != 2'b00) begin
        mode = 2;
        k = 0;
        mop = OP;
      end else e_err = REQ;
    end else k++;
    if (mode == 0) begin
      e_rn = (k >= P);
      e_setn = 1'b1;
      e_cap = (k >= P + R);
      e_busy = !e_cap;
      if (e_cap) mode = 1;
    end else if (mode == 2) begin
      int sl, e;
      sl = (mop == 2'b11) ? S : 0;
      e = 1 + P + sl + R;
      e_rn = !(mop[0] && k >= 1 && k < 1 + P);
      e_setn = !(mop[1] && k >= 1 && k < 1 + P + sl);
      e_cap = (k >= e);
      e_busy = (k < e);
      e_ack = (k == e);
      if (k == e) mode = 1;
    end else begin
      e_rn = 1'b1;
      e_setn = 1'b1;
      e_cap = 1'b1;
      e_busy = 1'b0;
    end
    started = 1'b1;
  end
  logic p_rn = 1'b1, p_setn = 1'b1;
  initial forever begin
    @(negedge CLK);
    if (started) begin
      chk("rn", RN, e_rn);
      chk("setn", SETN, e_setn);
      chk("cap_en", CAP_EN, e_cap);
      chk("busy", BUSY, e_busy);
      chk("ack", ACK, e_ack);
      chk("err", ERR, e_err);
      if (!p_rn && !p_setn) chk("no_joint_rise", RN && SETN, 1'b0);
      p_rn = RN;
      p_setn = SETN;
    end
  end
  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic go(logic [1:0] o);
    REQ = 1'b1;
    OP = o;
    step(1);
    REQ = 1'b0;
  endtask
  initial begin
    step(3);
    chk("rst_rn", RN, 1'b0);
    chk("rst_cap", CAP_EN, 1'b0);
    chk("rst_busy", BUSY, 1'b1);
    RST = 1'b0;
    step(1); chk("init_e1_rn", RN, 1'b0);
    step(1); chk("init_e2_rn", RN, 1'b1); chk("init_e2_cap", CAP_EN, 1'b0);
    step(2); chk("init_e4_cap", CAP_EN, 1'b1); chk("init_e4_busy", BUSY, 1'b0);
    step(2);
    go(2'b01); chk("clr_t0_cap", CAP_EN, 1'b0);
    step(1); chk("clr_t1_rn", RN, 1'b0); chk("clr_t1_setn", SETN, 1'b1);
    step(2); chk("clr_t3_rn", RN, 1'b1);
    step(2); chk("clr_t5_cap", CAP_EN, 1'b1); chk("clr_t5_ack", ACK, 1'b1);
    step(1); chk("clr_t6_ack", ACK, 1'b0);
    step(2);
    go(2'b11);
    step(1); chk("both_t1_rn", RN, 1'b0); chk("both_t1_setn", SETN, 1'b0);
    step(2); chk("both_t3_rn", RN, 1'b1); chk("both_t3_setn", SETN, 1'b0);
    step(1); chk("both_t4_setn", SETN, 1'b1);
    step(2); chk("both_t6_ack", ACK, 1'b1);
    step(2);
    go(2'b00); chk("ill_err", ERR, 1'b1); chk("ill_rn", RN, 1'b1); chk("ill_cap", CAP_EN, 1'b1);
    step(1); chk("ill_err_drop", ERR, 1'b0);
    step(1);
    go(2'b01);
    step(1);
    REQ = 1'b1;
    OP = 2'b10;
    step(2); chk("busy_t3_rn", RN, 1'b1); chk("busy_t3_setn", SETN, 1'b1);
    REQ = 1'b0;
    OP = 2'b00;
    step(2); chk("busy_t5_ack", ACK, 1'b1);
    step(2);
    go(2'b10);
    step(1); chk("abort_t1_setn", SETN, 1'b0);
    step(1);
    RST = 1'b1;
    step(1); chk("abort_setn", SETN, 1'b1); chk("abort_rn", RN, 1'b0); chk("abort_cap", CAP_EN, 1'b0);
    RST = 1'b0;
    step(1); chk("abort_e1_rn", RN, 1'b0);
    step(1); chk("abort_e2_rn", RN, 1'b1);
    step(2); chk("abort_e4_cap", CAP_EN, 1'b1);
    step(2);
    REQ = 1'b1;
    OP = 2'b01;
    step(1); chk("b2b_t0_cap", CAP_EN, 1'b0);
    step(5); chk("b2b_t5_ack", ACK, 1'b1); chk("b2b_t5_cap", CAP_EN, 1'b1);
    step(1); chk("b2b_t6_cap", CAP_EN, 1'b0); chk("b2b_t6_busy", BUSY, 1'b1);
    REQ = 1'b0;
    step(5); chk("b2b_2nd_ack", ACK, 1'b1);
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dffrsnq_ctrl_seq.md
Name: dffrsnq_ctrl_seq

Overview:
- Sequencer that drives the active-low asynchronous RN/SETN controls of a bank of dffrsnq flops from the synchronous domain.
- Enforces the bank's timing contract:
  - minimum RN/SETN low pulse width;
  - RN→SETN release separation (setup/hold between the two controls);
  - recovery/removal before the next capture clock edge.
- Capture is held off through CAP_EN, which feeds the bank's clock gate.
- Sits between the control/CSR logic and each set/reset register bank.

Parameters:
- CW, 4: width of the internal cycle counter.
- PULSE_CYC, 2: cycles RN/SETN are held low. Range 1..2^CW-1.
- SEP_CYC, 1: cycles between RN release and SETN release when both are asserted. Range 1..2^CW-1.
- REC_CYC, 2: cycles CAP_EN stays low after the last control release. Range 1..2^CW-1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  request level. Sampled only in IDLE.
- OP  in  2  operation code:
  - bit0 = assert RN (clear);
  - bit1 = assert SETN (preset);
  - 11 = both;
  - 00 = illegal.
- BUSY  out  1  high while a sequence or the reset-release sequence is running.
- ACK  out  1  one-cycle pulse when a requested sequence completes.
- ERR  out  1  one-cycle pulse when REQ is sampled with OP=00.
- RN  out  1  active-low clear to the bank. Registered.
- SETN  out  1  active-low preset to the bank. Registered.
- CAP_EN  out  1  bank capture enable. Registered.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- States: INIT, IDLE, QUIESCE, ASSERT, SEP, RECOVER, DONE.
- While RST=1:
  - state=INIT, counter=0;
  - RN=0, SETN=1, CAP_EN=0, BUSY=1, ACK=0, ERR=0.
- INIT, after RST falls:
  - hold RN=0 for PULSE_CYC more cycles, then set RN=1;
  - then go to RECOVER;
  - this path ends in IDLE with no ACK.
- IDLE:
  - RN=1, SETN=1, CAP_EN=1, BUSY=0.
  - Edge T0 with REQ=1 and OP≠00: latch OP, go to QUIESCE, CAP_EN=0, BUSY=1.
  - Edge with REQ=1 and OP=00: ERR=1 for one cycle, stay in IDLE.
- QUIESCE: one cycle. At T1: RN=~OP[0], SETN=~OP[1], go to ASSERT. Gives one full cycle of CAP_EN=0 before the async controls assert.
- ASSERT: PULSE_CYC cycles. At T1+PULSE_CYC: RN=1 (SETN=1 as well if OP=10).
  - OP=11: go to SEP.
  - Otherwise: go to RECOVER.
- SEP (OP=11 only): SEP_CYC cycles, then SETN=1, go to RECOVER.
  - RN and SETN never rise on the same edge.
  - Bank ends in the preset state.
- RECOVER: REC_CYC cycles with CAP_EN=0. Then:
  - requested sequence: DONE;
  - INIT path: IDLE with CAP_EN=1, BUSY=0.
- DONE is entered together with CAP_EN=1, ACK=1, BUSY=0. It lasts one cycle, then IDLE.
- REQ is ignored while BUSY=1:
  - no queueing, no ERR;
  - OP changes during a sequence are ignored.
- ACK/REQ handshake:
  - the requester drops REQ on the ACK cycle;
  - a REQ still high on the edge after ACK starts a new sequence;
  - that gives a minimum of one cycle at CAP_EN=1 between sequences.
- Invariants:
  - CAP_EN=0 whenever RN=0 or SETN=0, and for REC_CYC cycles after the last release;
  - RN and SETN only fall in the QUIESCE→ASSERT transition (or in INIT).
- RST mid-sequence: enters INIT on the next edge, forcing SETN=1 and RN=0.
  - Any SETN release concurrent with RN low is legal: clear dominates in the bank.
  - No ACK is issued for the aborted sequence.

Test Plan:
- Reset: RST high 3 cycles, then low.
  - During reset: RN=0, CAP_EN=0, BUSY=1.
  - RN=1 exactly 2 cycles after RST falls; CAP_EN=1, BUSY=0 2 cycles later; ACK never pulses.
- Clear, defaults, OP=01, REQ accepted at T0:
  - CAP_EN=0 at T0; RN=0 at T1; RN=1 at T3; CAP_EN=1 and ACK=1 at T5; ACK=0 at T6; SETN stays 1 throughout.
- Both, OP=11:
  - RN=SETN=0 at T1; RN=1 at T3; SETN=1 at T4; ACK at T6;
  - check that RN and SETN never rise on the same edge.
- Illegal and busy:
  - OP=00 with REQ in IDLE → single ERR pulse, outputs unchanged.
  - REQ re-pulsed with a new OP mid-sequence → ignored; the original timing is unchanged.
- Abort: RST asserted at T2 of an OP=10 sequence → next edge SETN=1, RN=0, CAP_EN=0, no ACK; INIT release timing then follows as in scenario 1.
- Back-to-back: REQ held high through ACK → second sequence accepted on the edge after ACK, with CAP_EN=1 for exactly one cycle between sequences.
